// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the handshaked data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Size 2'b11 falls into the default arm and behaves as a word.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << off;
            SZ_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Right-justifies the selected lanes of a read word and sign/zero extends them.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        b       = shifted[7:0];
        h       = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: result = {{24{b[7] & ~uns}}, b};
            SZ_HALF: result = {{16{h[15] & ~uns}}, h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked byte-lane data memory with configurable response latency.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses via rsp_err.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LATENCY     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_rdata_q, pend_rdata_d;
    logic             pend_err_q, pend_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic             accept, bad, wr_en;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [3:0]       be;
    logic [31:0]      wlanes, rd_word, ld_data, acc_rdata;

    assign idx = req_addr[IDX_W+1:2];
    assign off = req_addr[1:0];
    assign be  = byte_en(req_size, off);

    // Upper address bits alias onto the array.
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign bad = misaligned(req_size, off);
`else
    assign bad = 1'b0;
`endif

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_we && !bad;

    always_comb begin
        case (req_size)
            SZ_BYTE: wlanes = {4{req_wdata[7:0]}};
            SZ_HALF: wlanes = {2{req_wdata[15:0]}};
            default: wlanes = req_wdata;
        endcase
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        always_ff @(posedge clk) begin
            if (wr_en && be[l]) begin
                mem[idx] <= wlanes[8*l +: 8];
            end
        end
        assign rd_word[8*l +: 8] = mem[idx];
    end

    dmem_load_align u_align (
        .word   (rd_word),
        .size   (req_size),
        .offset (off),
        .uns    (req_unsigned),
        .result (ld_data)
    );

    assign acc_rdata = (req_we || bad) ? 32'h0 : ld_data;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_rdata_d = pend_rdata_q;
        pend_err_d   = pend_err_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = 32'h0;
        rsp_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = acc_rdata;
                        rsp_err_d   = bad;
                    end else begin
                        pend_rdata_d = acc_rdata;
                        pend_err_d   = bad;
                        cnt_d        = CNT_W'(LATENCY - 1);
                        state_d      = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pend_rdata_q;
                    rsp_err_d   = pend_err_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_rdata_q <= 32'h0;
            pend_err_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_rdata_q <= pend_rdata_d;
            pend_err_q   <= pend_err_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one LATENCY=1 and one LATENCY=3 instance against a byte-array model.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        v    [2];
    logic        we_s [2];
    logic        un_s [2];
    logic [1:0]  sz_s [2];
    logic [31:0] ad_s [2];
    logic [31:0] wd_s [2];
    logic        rdy  [2];
    logic        rv   [2];
    logic [31:0] rd_s [2];
    logic        er_s [2];

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned model_mem [2][2048];

    typedef struct {
        int          d;
        bit          we;
        bit [1:0]    sz;
        bit          un;
        bit [31:0]   addr;
        bit [31:0]   wd;
        bit [31:0]   exp_rd;
        bit          exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    dmem_ctrl #(.DEPTH_WORDS(512), .ADDR_W(32), .LATENCY(1)) u_dut_l1 (
        .clk          (clk),
        .reset        (rst[0]),
        .req_valid    (v[0]),
        .req_ready    (rdy[0]),
        .req_we       (we_s[0]),
        .req_size     (sz_s[0]),
        .req_unsigned (un_s[0]),
        .req_addr     (ad_s[0]),
        .req_wdata    (wd_s[0]),
        .rsp_valid    (rv[0]),
        .rsp_rdata    (rd_s[0]),
        .rsp_err      (er_s[0])
    );

    dmem_ctrl #(.DEPTH_WORDS(512), .ADDR_W(32), .LATENCY(3)) u_dut_l3 (
        .clk          (clk),
        .reset        (rst[1]),
        .req_valid    (v[1]),
        .req_ready    (rdy[1]),
        .req_we       (we_s[1]),
        .req_size     (sz_s[1]),
        .req_unsigned (un_s[1]),
        .req_addr     (ad_s[1]),
        .req_wdata    (wd_s[1]),
        .rsp_valid    (rv[1]),
        .rsp_rdata    (rd_s[1]),
        .rsp_err      (er_s[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed array, aligned base, arithmetic sign extension.
    function automatic void model_txn(input int d, input bit we, input bit [1:0] sz,
                                      input bit un, input bit [31:0] addr, input bit [31:0] wd,
                                      output bit [31:0] rd, output bit err);
        int     n;
        int     base;
        longint val;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        rd  = 32'h0;
        err = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (addr % n != 0) begin
            err = 1'b1;
            return;
        end
`endif
        base = int'((addr - addr % n) % 2048);
        if (we) begin
            for (int i = 0; i < n; i++) model_mem[d][base + i] = 8'(wd >> (8 * i));
        end else begin
            val = 0;
            for (int i = 0; i < n; i++) val += longint'(model_mem[d][base + i]) << (8 * i);
            if (!un && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= longint'(1) << (8 * n);
            rd = val[31:0];
        end
    endfunction

    task automatic drive(input int d, input bit we, input bit [1:0] sz, input bit un,
                         input bit [31:0] addr, input bit [31:0] wd);
        v[d]    = 1'b1;
        we_s[d] = we;
        sz_s[d] = sz;
        un_s[d] = un;
        ad_s[d] = addr;
        wd_s[d] = wd;
    endtask

    // One transaction; checks that rsp_valid appears only in the LATENCY-th cycle.
    task automatic txn(input int d, input bit we, input bit [1:0] sz, input bit un,
                       input bit [31:0] addr, input bit [31:0] wd,
                       output bit [31:0] rd, output bit err);
        int        k;
        bit        seen;
        bit [7:0]  pat;
        drive(d, we, sz, un, addr, wd);
        k = 0;
        @(negedge clk);
        while (!rdy[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!rdy[d]) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: dut %0d req_ready stayed 0 for %0d cycles", d, k);
        end
        @(posedge clk);
        #1;
        v[d] = 1'b0;
        seen = 1'b0;
        pat  = 8'h0;
        rd   = 32'h0;
        err  = 1'b0;
        for (int c = 1; c <= lat_of(d) + 1; c++) begin
            @(negedge clk);
            if (rv[d] === 1'b1) begin
                pat[c-1] = 1'b1;
                if (!seen) begin
                    rd   = rd_s[d];
                    err  = er_s[d];
                    seen = 1'b1;
                end
            end
        end
        chk($sformatf("rsp_timing_d%0d", d), {24'h0, pat}, 32'h1 << (lat_of(d) - 1));
    endtask

    task automatic add_vec(input int d, input bit we, input bit [1:0] sz, input bit un,
                           input bit [31:0] addr, input bit [31:0] wd,
                           input bit [31:0] exp_rd, input bit exp_err, input string name);
        vec_t t;
        t.d = d; t.we = we; t.sz = sz; t.un = un; t.addr = addr; t.wd = wd;
        t.exp_rd = exp_rd; t.exp_err = exp_err; t.name = name;
        vecs.push_back(t);
    endtask

    bit trap;

    initial begin
        bit [31:0] rd, mrd;
        bit        er, mer;
        bit [6:0]  rvpat, rdypat;
        bit [31:0] got_a, got_b;
        bit [3:0]  rpat;

`ifdef DMEM_MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; v[d] = 1'b0; we_s[d] = 1'b0; un_s[d] = 1'b0;
            sz_s[d] = 2'd0; ad_s[d] = 32'h0; wd_s[d] = 32'h0;
        end

        add_vec(0, 1, 2, 0, 32'h10, 32'h0, 32'h0, 0, "st_w0x10");
        add_vec(0, 1, 0, 0, 32'h12, 32'h80, 32'h0, 0, "st_b0x12");
        add_vec(0, 0, 0, 0, 32'h12, 32'h0, 32'hFFFFFF80, 0, "ld_sb0x12");
        add_vec(0, 0, 0, 1, 32'h12, 32'h0, 32'h00000080, 0, "ld_ub0x12");
        add_vec(0, 0, 2, 0, 32'h10, 32'h0, 32'h00800000, 0, "ld_w0x10");
        add_vec(0, 1, 2, 0, 32'h20, 32'h12345678, 32'h0, 0, "st_w0x20");
        add_vec(0, 1, 1, 0, 32'h22, 32'h0000BEEF, 32'h0, 0, "st_h0x22");
        add_vec(0, 0, 1, 0, 32'h22, 32'h0, 32'hFFFFBEEF, 0, "ld_sh0x22");
        add_vec(0, 0, 2, 0, 32'h20, 32'h0, 32'hBEEF5678, 0, "ld_w0x20");
        add_vec(0, 1, 2, 0, 32'h800, 32'hCAFEF00D, 32'h0, 0, "st_wrap");
        add_vec(0, 0, 2, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0, "ld_wrap");
        add_vec(0, 1, 2, 0, 32'h4, 32'h11111111, 32'h0, 0, "st_w0x4");
        add_vec(0, 1, 2, 0, 32'h5, 32'h11223344, 32'h0, trap, "st_mis0x5");
        add_vec(0, 0, 2, 0, 32'h4, 32'h0, trap ? 32'h11111111 : 32'h11223344, 0, "ld_w0x4");
        add_vec(1, 1, 1, 0, 32'h32, 32'h00008001, 32'h0, 0, "l3_st_h0x32");
        add_vec(1, 0, 1, 0, 32'h32, 32'h0, 32'hFFFF8001, 0, "l3_ld_sh0x32");
        add_vec(1, 0, 0, 1, 32'h33, 32'h0, 32'h00000080, 0, "l3_ld_ub0x33");
        add_vec(1, 0, 3, 0, 32'h30, 32'h0, 32'h80010000, 0, "l3_ld_sz3");

        // Reset behaviour.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready_d%0d", d), {31'h0, rdy[d]}, 32'h0);
            chk($sformatf("rst_valid_d%0d", d), {31'h0, rv[d]}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("post_rst_ready_d%0d", d), {31'h0, rdy[d]}, 32'h1);
            chk($sformatf("post_rst_valid_d%0d", d), {31'h0, rv[d]}, 32'h0);
            chk($sformatf("post_rst_rdata_d%0d", d), rd_s[d], 32'h0);
            chk($sformatf("post_rst_err_d%0d", d), {31'h0, er_s[d]}, 32'h0);
        end

        // Array contents are never reset, so give every word a known value.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 512; w++) begin
                txn(d, 1, 2, 0, 32'(w * 4), 32'h0, rd, er);
                model_txn(d, 1, 2, 0, 32'(w * 4), 32'h0, mrd, mer);
            end
        end

        foreach (vecs[i]) begin
            txn(vecs[i].d, vecs[i].we, vecs[i].sz, vecs[i].un, vecs[i].addr, vecs[i].wd, rd, er);
            model_txn(vecs[i].d, vecs[i].we, vecs[i].sz, vecs[i].un, vecs[i].addr, vecs[i].wd,
                      mrd, mer);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
            chk({vecs[i].name, "_err"}, {31'h0, er}, {31'h0, vecs[i].exp_err});
        end

        // Back-to-back store then load of the same word at LATENCY=1.
        @(negedge clk);
        chk("b2b_ready", {31'h0, rdy[0]}, 32'h1);
        drive(0, 1, 2, 0, 32'h60, 32'h55AA33CC);
        @(posedge clk);
        #1;
        drive(0, 0, 2, 0, 32'h60, 32'h0);
        @(negedge clk);
        chk("b2b_st_valid", {31'h0, rv[0]}, 32'h1);
        chk("b2b_st_rdata", rd_s[0], 32'h0);
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        @(negedge clk);
        chk("b2b_ld_valid", {31'h0, rv[0]}, 32'h1);
        chk("b2b_ld_rdata", rd_s[0], 32'h55AA33CC);
        @(negedge clk);
        chk("b2b_idle_valid", {31'h0, rv[0]}, 32'h0);
        model_txn(0, 1, 2, 0, 32'h60, 32'h55AA33CC, mrd, mer);

        // LATENCY=3: second request held through BUSY is taken when ready returns.
        txn(1, 1, 2, 0, 32'h70, 32'h0BADF00D, rd, er);
        model_txn(1, 1, 2, 0, 32'h70, 32'h0BADF00D, mrd, mer);
        txn(1, 1, 2, 0, 32'h74, 32'h600DCAFE, rd, er);
        model_txn(1, 1, 2, 0, 32'h74, 32'h600DCAFE, mrd, mer);
        @(negedge clk);
        chk("held_ready0", {31'h0, rdy[1]}, 32'h1);
        drive(1, 0, 2, 0, 32'h70, 32'h0);
        @(posedge clk);
        #1;
        drive(1, 0, 2, 0, 32'h74, 32'h0);
        rvpat = '0; rdypat = '0; got_a = 32'h0; got_b = 32'h0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            rvpat[c-1]  = (rv[1] === 1'b1);
            rdypat[c-1] = (rdy[1] === 1'b1);
            if (c == 3) got_a = rd_s[1];
            if (c == 6) got_b = rd_s[1];
            if (c == 3) begin
                @(posedge clk);
                #1;
                v[1] = 1'b0;
            end
        end
        chk("held_rsp_pattern", {25'h0, rvpat}, 32'b0100100);
        chk("held_ready_pattern", {25'h0, rdypat}, 32'b1100100);
        chk("held_first_rdata", got_a, 32'h0BADF00D);
        chk("held_second_rdata", got_b, 32'h600DCAFE);

        // Reset right after a LATENCY=3 store is accepted.
        @(negedge clk);
        drive(1, 1, 2, 0, 32'h40, 32'hA5A55A5A);
        @(posedge clk);
        #1;
        v[1]   = 1'b0;
        rst[1] = 1'b1;
        @(negedge clk);
        chk("midrst_ready_low", {31'h0, rdy[1]}, 32'h0);
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        rpat = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) chk("midrst_ready_after", {31'h0, rdy[1]}, 32'h1);
            rpat[c-1] = (rv[1] === 1'b1);
        end
        chk("midrst_no_rsp", {28'h0, rpat}, 32'h0);
        model_txn(1, 1, 2, 0, 32'h40, 32'hA5A55A5A, mrd, mer);
        txn(1, 0, 2, 0, 32'h40, 32'h0, rd, er);
        chk("midrst_data_kept", rd, 32'hA5A55A5A);

        // Random traffic on both instances against the model.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 300; i++) begin
                bit        rwe, run;
                bit [1:0]  rsz;
                bit [31:0] raddr, rwd;
                rwe   = 1'($urandom_range(0, 1));
                run   = 1'($urandom_range(0, 1));
                rsz   = 2'($urandom_range(0, 3));
                raddr = (32'($urandom_range(0, 3)) << 11) | 32'($urandom_range(0, 127));
                rwd   = $urandom;
                txn(d, rwe, rsz, run, raddr, rwd, rd, er);
                model_txn(d, rwe, rsz, run, raddr, rwd, mrd, mer);
                chk($sformatf("rand_d%0d_%0d_rdata", d, i), rd, mrd);
                chk($sformatf("rand_d%0d_%0d_err", d, i), {31'h0, er}, {31'h0, mer});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, handshaked data memory for the core's load/store unit, the next-generation replacement for the single-cycle byte-lane data RAM. It stores DEPTH_WORDS 32-bit words as four byte lanes and supports byte, halfword and word accesses with sign or zero extension on loads. It adds a valid/ready request port, a configurable access latency and, optionally, a misalignment trap. It sits between the LSU and the data array in the memory stage.

## Interface
- DEPTH_WORDS, 512: number of 32-bit words; power of two, ≥ 4.
- ADDR_W, 32: byte-address width.
- LATENCY, 1: number of edges from request acceptance to response; ≥ 1.
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse, for loads and stores.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  misaligned access; see Configuration.

## Operation
- Word index is req_addr[$clog2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so the address wraps.
- Lane selection: byte uses lane addr[1:0]; half uses lanes {addr[1],0} and {addr[1],1}; word uses all four lanes.
- Stores write only the selected lanes. Byte and half data come from req_wdata[7:0] and req_wdata[15:0]. Unselected lanes are unchanged.
- Loads right-justify the selected lanes and then extend according to req_unsigned.
- The block holds one transaction at a time. FSM states:
  - IDLE: req_ready = 1. On acceptance (req_valid && req_ready): if LATENCY == 1, stay in IDLE; otherwise load cnt = LATENCY-1 and go to BUSY.
  - BUSY: req_ready = 0. cnt decrements each edge. When cnt reaches 1, return to IDLE.
- A request with req_valid = 0 has no effect. Request inputs are ignored whenever req_ready = 0.

## Timing
- Both the store write and the load data capture happen on the acceptance edge (edge 1).
- Response timing: rsp_valid, rsp_rdata and rsp_err are registered. They are valid for exactly the one cycle after the LATENCY-th edge, counting the acceptance edge as edge 1.
- req_ready is 1 during the response cycle, so throughput is one transaction per LATENCY cycles. With LATENCY = 1, back-to-back requests are accepted every cycle.
- A load accepted immediately after a store to the same word returns the new data.
- Reset values: state IDLE, cnt 0, rsp_valid 0, rsp_rdata 0, rsp_err 0. req_ready is 0 while reset is high and 1 in the first cycle after reset.
- Reset mid-transaction: the in-flight response is dropped (no rsp_valid). A store already committed on its acceptance edge remains in the array. Array contents are never reset.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, is misaligned.
  - A misaligned access performs no write and returns rsp_rdata = 0 and rsp_err = 1, with the normal latency.
- DMEM_MISALIGN_TRAP_EN undefined:
  - Half accesses ignore addr[0] and word accesses ignore addr[1:0].
  - rsp_err is tied to 0.

## Structure
- dmem_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the FSM state enum (S_IDLE, S_BUSY);
  - a function computing the 4-bit byte-enable from size and addr[1:0].
- Sub-module dmem_load_align: combinational lane extraction and sign/zero extension. Inputs are the 32-bit word, size, addr[1:0] and unsigned; output is the 32-bit result.
- The array is four 8-bit × DEPTH_WORDS lane memories in dmem_ctrl itself, written under the byte-enable.

## Test plan
- Byte store then loads, LATENCY = 1:
  - store word 0x00000000 @0x10; store byte 0x80 @0x12.
  - signed byte load @0x12 → 0xFFFFFF80.
  - unsigned byte load @0x12 → 0x00000080.
  - word load @0x10 → 0x00800000.
- Halfword: store half 0xBEEF @0x22; signed half load @0x22 → 0xFFFFBEEF; word load @0x20 → 0xBEEFxxxx, with the low half unchanged.
- LATENCY = 3:
  - a load accepted at edge 0 gives rsp_valid only in the cycle after edge 2;
  - req_ready is 0 for 2 cycles;
  - a second req_valid held during BUSY is accepted only when req_ready returns.
- Address wrap, DEPTH_WORDS = 512: store word 0xCAFEF00D @0x800; word load @0x0 → 0xCAFEF00D.
- Misalignment, word store 0x11223344 @0x5:
  - with DMEM_MISALIGN_TRAP_EN: rsp_err = 1 and the word @0x4 is unchanged;
  - without the macro: the word @0x4 becomes 0x11223344 and rsp_err = 0.
- Reset at edge 1 of a LATENCY = 3 store: no rsp_valid; the stored data is readable after reset; req_ready = 1 in the cycle after reset.
